// File: rtl/pulse_frame_tx.sv
// Framed serial pulse transmitter: high start bit, DATA_W bits MSB first, low stop bit, each held BIT_CYCLES clocks.
// One cycle from handshake to line rise; tx_ready only in IDLE, so words offered mid-frame wait for the done cycle.
module pulse_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [CW-1:0]     r_cyc_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_done;

  logic w_cyc_end;
  logic w_load;
  logic w_cyc_clr;
  logic w_cyc_inc;
  logic w_shift;
  logic w_bit_inc;
  logic w_done_set;

  assign w_cyc_end = (r_cyc_cnt == CYC_LAST);
  assign done      = r_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Line outputs decode from r_state only; tx_valid affects next state, never this cycle's pins.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cyc_clr   = 1'b0;
    w_cyc_inc   = 1'b0;
    w_shift     = 1'b0;
    w_bit_inc   = 1'b0;
    w_done_set  = 1'b0;
    tx_ready    = 1'b0;
    busy        = 1'b0;
    serial_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        busy       = 1'b1;
        serial_out = 1'b1;
        if (w_cyc_end) begin
          w_cyc_clr   = 1'b1;
          w_state_nxt = S_DATA;
        end else begin
          w_cyc_inc = 1'b1;
        end
      end
      S_DATA: begin
        busy       = 1'b1;
        serial_out = r_shreg[DATA_W-1];
        if (w_cyc_end) begin
          w_shift   = 1'b1;
          w_cyc_clr = 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_inc = 1'b1;
          end
        end else begin
          w_cyc_inc = 1'b1;
        end
      end
      S_STOP: begin
        busy = 1'b1;
        if (w_cyc_end) begin
          w_cyc_clr   = 1'b1;
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cyc_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shreg   <= '0;
      r_cyc_cnt <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_load) begin
        r_shreg   <= tx_data;
        r_cyc_cnt <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_cyc_clr) begin
          r_cyc_cnt <= '0;
        end else if (w_cyc_inc) begin
          r_cyc_cnt <= r_cyc_cnt + CW'(1);
        end
        if (w_shift) begin
          r_shreg <= r_shreg << 1;
        end
        if (w_bit_inc) begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_frame_tx.sv
// Directed bench for pulse_frame_tx: an 8-bit/4-cycle instance and an 8-bit/1-cycle instance share clock and reset.
module tb_pulse_frame_tx;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] a_tx_data;
  logic       a_tx_valid;
  logic       a_tx_ready;
  logic       a_serial_out;
  logic       a_busy;
  logic       a_done;
  logic [7:0] b_tx_data;
  logic       b_tx_valid;
  logic       b_tx_ready;
  logic       b_serial_out;
  logic       b_busy;
  logic       b_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pulse_frame_tx #(.DATA_W(8), .BIT_CYCLES(4)) u_dut_a (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (a_tx_data),
    .tx_valid   (a_tx_valid),
    .tx_ready   (a_tx_ready),
    .serial_out (a_serial_out),
    .busy       (a_busy),
    .done       (a_done)
  );

  pulse_frame_tx #(.DATA_W(8), .BIT_CYCLES(1)) u_dut_b (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (b_tx_data),
    .tx_valid   (b_tx_valid),
    .tx_ready   (b_tx_ready),
    .serial_out (b_serial_out),
    .busy       (b_busy),
    .done       (b_done)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected line level in cycle k after the accepting edge (b = clocks per bit, 8 data bits).
  function automatic logic exp_line(input logic [7:0] d, input int k, input int b);
    int j;
    if (k >= 1 && k <= b) return 1'b1;
    if (k > b && k <= b * 9) begin
      j = (k - b - 1) / b;
      return d[3'(7 - j)];
    end
    return 1'b0;
  endfunction

  task automatic cyc_chk(input string tag, input int k, input int b, input logic [7:0] d,
                         input logic so, input logic bz, input logic dn, input logic rd);
    chk($sformatf("%s_c%0d_line", tag, k), so, exp_line(d, k, b));
    chk($sformatf("%s_c%0d_busy", tag, k), bz, (k >= 1 && k <= b * 10));
    chk($sformatf("%s_c%0d_done", tag, k), dn, (k == b * 10 + 1));
    chk($sformatf("%s_c%0d_rdy", tag, k), rd, !(k >= 1 && k <= b * 10));
  endtask

  // Leaves tx_valid high; the caller's first cycle of the frame drops it.
  task automatic a_handshake(input logic [7:0] d);
    @(negedge clk);
    a_tx_data  = d;
    a_tx_valid = 1'b1;
    chk("hs_rdy", a_tx_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic a_frame(input string tag, input logic [7:0] d, input int kmax);
    a_handshake(d);
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      if (k == 1) a_tx_valid = 1'b0;
      cyc_chk(tag, k, 4, d, a_serial_out, a_busy, a_done, a_tx_ready);
    end
  endtask

  // Asynchronous abort a few ns after a negedge, checked before the next rising edge.
  task automatic a_abort(input string tag);
    #2 resetn = 1'b0;
    #1;
    chk({tag, "_line"}, a_serial_out, 1'b0);
    chk({tag, "_busy"}, a_busy, 1'b0);
    chk({tag, "_done"}, a_done, 1'b0);
    chk({tag, "_rdy"}, a_tx_ready, 1'b1);
    a_tx_data  = 8'h11;
    a_tx_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_held_busy"}, a_busy, 1'b0);
    chk({tag, "_held_line"}, a_serial_out, 1'b0);
    a_tx_valid = 1'b0;
    resetn     = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("%s_post%0d_done", tag, k), a_done, 1'b0);
      chk($sformatf("%s_post%0d_busy", tag, k), a_busy, 1'b0);
      chk($sformatf("%s_post%0d_line", tag, k), a_serial_out, 1'b0);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    a_tx_data  = 8'h00;
    a_tx_valid = 1'b0;
    b_tx_data  = 8'h00;
    b_tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_line", a_serial_out, 1'b0);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_done", a_done, 1'b0);
    chk("rst_a_rdy", a_tx_ready, 1'b1);
    chk("rst_b_line", b_serial_out, 1'b0);
    chk("rst_b_rdy", b_tx_ready, 1'b1);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_a_line", a_serial_out, 1'b0);
    chk("idle_a_rdy", a_tx_ready, 1'b1);

    // Single 0xA5 frame plus two idle cycles after done.
    a_frame("single", 8'hA5, 43);

    // Async reset while the line is high in the middle of a 0xFF frame.
    a_handshake(8'hFF);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) a_tx_valid = 1'b0;
      cyc_chk("pre6", k, 4, 8'hFF, a_serial_out, a_busy, a_done, a_tx_ready);
    end
    a_abort("rst6");

    // Back-to-back: tx_valid held; tx_data changes to 0x00 during the first frame.
    a_handshake(8'hFF);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 10) a_tx_data = 8'h00;
      cyc_chk("b2b1", k, 4, 8'hFF, a_serial_out, a_busy, a_done, a_tx_ready);
    end
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 1) a_tx_valid = 1'b0;
      cyc_chk("b2b2", k, 4, 8'h00, a_serial_out, a_busy, a_done, a_tx_ready);
    end

    // Busy rejection: a 0x3C pulse during DATA of 0x81 is ignored.
    a_handshake(8'h81);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) a_tx_valid = 1'b0;
      if (k == 15) begin
        a_tx_data  = 8'h3C;
        a_tx_valid = 1'b1;
      end
      if (k == 16) a_tx_valid = 1'b0;
      cyc_chk("rej", k, 4, 8'h81, a_serial_out, a_busy, a_done, a_tx_ready);
    end

    // Reset at cycle 20 of 0xA5, then a clean 0x5A frame.
    a_handshake(8'hA5);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) a_tx_valid = 1'b0;
      cyc_chk("pre20", k, 4, 8'hA5, a_serial_out, a_busy, a_done, a_tx_ready);
    end
    a_abort("rst20");
    a_frame("post", 8'h5A, 42);

    // One clock per bit: line high 1..9, low at 10, done at 11.
    @(negedge clk);
    b_tx_data  = 8'hFF;
    b_tx_valid = 1'b1;
    chk("min_hs_rdy", b_tx_ready, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) b_tx_valid = 1'b0;
      cyc_chk("min", k, 1, 8'hFF, b_serial_out, b_busy, b_done, b_tx_ready);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_frame_tx.md
# pulse_frame_tx

Serial frame transmitter that generates the single-line pulse pattern our Moore pattern detectors consume. It accepts a parallel word over a valid/ready handshake and drives `serial_out` with a framed waveform:
- a high start bit,
- the data bits, MSB first,
- a low stop/guard bit.

Each bit is held for `BIT_CYCLES` clocks. The block sits on the stimulus/transmit side of the serial link, opposite the detector FSM.

## Interface
- `DATA_W`, default 8: data word width; legal range ≥1.
- `BIT_CYCLES`, default 4: clocks per transmitted bit; legal range ≥1.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  `DATA_W`  word to send; sampled only on handshake.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  block can accept; equals (state==IDLE).
- `serial_out`  out  1  serial line, idle low.
- `busy`  out  1  high in START, DATA and STOP.
- `done`  out  1  one-cycle pulse after the last STOP cycle.

## Operation
- Moore FSM with states IDLE, START, DATA and STOP, held in `state` (2 bits). `serial_out`, `tx_ready` and `busy` decode from registered state only.
- Datapath:
  - `shreg` (`DATA_W` bits) holds the word.
  - `cyc_cnt` counts 0..`BIT_CYCLES`-1 within a bit; size its width for `BIT_CYCLES`=1.
  - `bit_cnt` counts 0..`DATA_W`-1.
- IDLE:
  - `serial_out`=0, `tx_ready`=1, `busy`=0.
  - On `tx_valid`&&`tx_ready`: latch `tx_data` into `shreg`, clear both counters, go to START.
- START:
  - `serial_out`=1.
  - When `cyc_cnt`==`BIT_CYCLES`-1: clear `cyc_cnt` and go to DATA. Otherwise increment `cyc_cnt`.
- DATA:
  - `serial_out`=`shreg`[`DATA_W`-1].
  - At end of each bit (`cyc_cnt`==`BIT_CYCLES`-1): shift `shreg` left by 1 and clear `cyc_cnt`.
  - If `bit_cnt`==`DATA_W`-1, go to STOP; otherwise increment `bit_cnt`.
- STOP:
  - `serial_out`=0.
  - When `cyc_cnt`==`BIT_CYCLES`-1: go to IDLE and set `done` for the next cycle.
- `done` is registered. It is high only in the first IDLE cycle after STOP, otherwise 0.
- Illegal or unreachable state encoding returns to IDLE next cycle, with `serial_out`=0.
- `tx_valid` while `tx_ready`=0 is ignored; no word is latched. Producers must hold `tx_data`/`tx_valid` until the handshake.
- Changes on `tx_data` after acceptance have no effect on the frame in flight.

## Timing
- Reset behaviour:
  - Reset asserted: `state`=IDLE, `shreg`=0, counters=0, `done`=0. Hence `serial_out`=0, `busy`=0, `tx_ready`=1.
  - No transfer occurs while `resetn` is low.
  - Reset mid-frame aborts the frame immediately (asynchronously). The line drops low and no `done` is issued.
- Cycle numbering: let edge E be the rising edge that samples `tx_valid`&&`tx_ready` high. Number the cycles following E as 1, 2, … With B=`BIT_CYCLES` and N=`DATA_W`:
  - Cycles 1..B: START, `serial_out`=1.
  - Data bit j (j=0 is the MSB): cycles B·(1+j)+1 .. B·(2+j).
  - STOP: cycles B·(N+1)+1 .. B·(N+2), `serial_out`=0.
  - Cycle B·(N+2)+1: IDLE with `done`=1 and `tx_ready`=1.
- Frame length is B·(N+2) cycles, and `busy` is high for exactly those cycles.
- Back-to-back frames:
  - A handshake may occur in the `done` cycle.
  - The minimum inter-frame gap is 1 cycle of `serial_out`=0 (IDLE), in addition to the B-cycle stop bit.
- Latency from handshake to the first line transition: 1 cycle.

## Test plan
- **Reset values:** assert `resetn`=0 mid-simulation → `serial_out`=0, `busy`=0, `done`=0, `tx_ready`=1 immediately.
- **Single frame:** `DATA_W`=8, `BIT_CYCLES`=4, send 0xA5.
  - `serial_out` for cycles 1-4 = 1.
  - Cycles 5-36 = 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - Cycles 37-40 = 0.
  - `done`=1 at cycle 41 only.
  - `busy` high for cycles 1-40.
- **Back-to-back:** hold `tx_valid`=1 with 0xFF then 0x00 → second handshake in cycle 41 (the `done` cycle); the second START begins at cycle 42. Change `tx_data` to 0x00 during the first frame → the first frame's waveform is unchanged.
- **Busy rejection:** pulse `tx_valid` with 0x3C during DATA of a 0x81 frame → `tx_ready`=0, the pulse is ignored, the 0x81 waveform is intact, and only one `done` is issued.
- **Reset mid-frame:** drop `resetn` at cycle 20 of a 0xA5 frame → `serial_out`=0 the same cycle. After release: IDLE, no `done`, and a new 0x5A frame transmits correctly.
- **Minimal timing:** `BIT_CYCLES`=1, `DATA_W`=8, send 0xFF → `serial_out` high for cycles 1-9, low in cycle 10, `done` at cycle 11.
